zcd_frame_deserializer: RTL

- Sits directly downstream of the ZCD pulse-interval decoder and consumes its per-bit decode strobe.
- Hunts for a 4-bit preamble in the decoded bit stream, then assembles a fixed-length payload into bytes (MSB first) and checks a trailing XOR checksum byte.
- Reports byte strobes, frame completion and classified frame errors to the link controller.
- Single clock domain: sclk_3mhz.

---
 rtl/zcd_frame_deserializer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/zcd_frame_deserializer.sv
// Frame deserializer behind the ZCD pulse-interval decoder: hunts for a preamble,
// assembles MSB-first payload bytes, verifies an XOR checksum and classifies errors.
module zcd_frame_deserializer #(
  parameter int unsigned PAYLOAD_BYTES  = 4,
  parameter logic [3:0]  PREAMBLE       = 4'b0101,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       sclk_3mhz,
  input  logic       reset_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       bit_err,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [3:0] LAST_BYTE  = 4'(PAYLOAD_BYTES - 1);
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  pre_sr_r, pre_sr_s;
  logic [2:0]  fill_r, fill_s;
  logic [6:0]  byte_sr_r, byte_sr_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [3:0]  byte_cnt_r, byte_cnt_s;
  logic [7:0]  csum_r, csum_s;
  logic [7:0]  idle_r, idle_s;
  logic [3:0]  pre_word_s;
  logic [7:0]  full_byte_s;
  logic [7:0]  rx_data_s;
  logic        rx_data_valid_s, frame_done_s, frame_err_s, busy_s;
  logic [1:0]  err_code_s;

  // Next-state and next-output computation for the whole receiver.
  always_comb begin
    state_s         = state_r;
    pre_sr_s        = pre_sr_r;
    fill_s          = fill_r;
    byte_sr_s       = byte_sr_r;
    bit_cnt_s       = bit_cnt_r;
    byte_cnt_s      = byte_cnt_r;
    csum_s          = csum_r;
    idle_s          = idle_r;
    rx_data_s       = rx_data;
    rx_data_valid_s = 1'b0;
    frame_done_s    = 1'b0;
    frame_err_s     = 1'b0;
    err_code_s      = err_code;
    pre_word_s      = {pre_sr_r, bit_in};
    full_byte_s     = {byte_sr_r, bit_in};

    case (state_r)
      HUNT: begin
        if (bit_err) begin
          pre_sr_s = 3'd0;
          fill_s   = 3'd0;
        end else if (bit_valid) begin
          pre_sr_s = pre_word_s[2:0];
          fill_s   = (fill_r == 3'd4) ? 3'd4 : fill_r + 3'd1;
          if ((fill_s == 3'd4) && (pre_word_s == PREAMBLE)) begin
            state_s    = PAYLOAD;
            err_code_s = 2'b00;
            csum_s     = 8'd0;
            bit_cnt_s  = 3'd0;
            byte_cnt_s = 4'd0;
            idle_s     = 8'd0;
            byte_sr_s  = 7'd0;
            pre_sr_s   = 3'd0;
            fill_s     = 3'd0;
          end else begin
            state_s = HUNT;
          end
        end else begin
          state_s = HUNT;
        end
      end

      PAYLOAD, CHECK: begin
        if (bit_err) begin
          frame_err_s = 1'b1;
          err_code_s  = 2'b10;
          state_s     = HUNT;
          pre_sr_s    = 3'd0;
          fill_s      = 3'd0;
          idle_s      = 8'd0;
        end else if (bit_valid) begin
          idle_s    = 8'd0;
          byte_sr_s = full_byte_s[6:0];
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            if (state_r == PAYLOAD) begin
              rx_data_s       = full_byte_s;
              rx_data_valid_s = 1'b1;
              csum_s          = csum_r ^ full_byte_s;
              byte_cnt_s      = byte_cnt_r + 4'd1;
              state_s         = (byte_cnt_r == LAST_BYTE) ? CHECK : PAYLOAD;
            end else begin
              // Checksum byte is consumed here and never forwarded as data.
              if (full_byte_s == csum_r) begin
                frame_done_s = 1'b1;
              end else begin
                frame_err_s = 1'b1;
                err_code_s  = 2'b01;
              end
              state_s  = HUNT;
              pre_sr_s = 3'd0;
              fill_s   = 3'd0;
            end
          end else begin
            state_s = state_r;
          end
        end else if (idle_r == IDLE_LIMIT) begin
          frame_err_s = 1'b1;
          err_code_s  = 2'b11;
          state_s     = HUNT;
          pre_sr_s    = 3'd0;
          fill_s      = 3'd0;
          idle_s      = 8'd0;
        end else begin
          idle_s = idle_r + 8'd1;
        end
      end

      default: begin
        state_s  = HUNT;
        pre_sr_s = 3'd0;
        fill_s   = 3'd0;
      end
    endcase

    busy_s = (state_s != HUNT);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge sclk_3mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= HUNT;
      pre_sr_r      <= 3'd0;
      fill_r        <= 3'd0;
      byte_sr_r     <= 7'd0;
      bit_cnt_r     <= 3'd0;
      byte_cnt_r    <= 4'd0;
      csum_r        <= 8'd0;
      idle_r        <= 8'd0;
      rx_data       <= 8'd0;
      rx_data_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state_r       <= state_s;
      pre_sr_r      <= pre_sr_s;
      fill_r        <= fill_s;
      byte_sr_r     <= byte_sr_s;
      bit_cnt_r     <= bit_cnt_s;
      byte_cnt_r    <= byte_cnt_s;
      csum_r        <= csum_s;
      idle_r        <= idle_s;
      rx_data       <= rx_data_s;
      rx_data_valid <= rx_data_valid_s;
      frame_done    <= frame_done_s;
      frame_err     <= frame_err_s;
      err_code      <= err_code_s;
      busy          <= busy_s;
    end
  end

endmodule
